// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if: serial lane, pattern load and match result bundle for seq_detect_param
interface seq_detect_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             w;
  logic             w_vld;
  logic             overlap;
  logic             pat_ld;
  logic [PAT_W-1:0] pat_in;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  modport master (output w, w_vld, overlap, pat_ld, pat_in, input z, match_cnt);
  modport slave (input w, w_vld, overlap, pat_ld, pat_in, output z, match_cnt);
endinterface

// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-loadable serial pattern detector; SEQ_DET_CNT_EN builds the saturating match counter
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1101,
  parameter int               CNT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  seq_detect_param_if.slave bus
);
  localparam int FW = $clog2(PAT_W + 1);
  logic [PAT_W-1:0] pat, hist, h_nx;
  logic [FW-1:0]    fill, f_nx;
  logic             z, hit, acc;
  always_comb begin
    h_nx = PAT_W'({hist, bus.w});
    f_nx = (fill == FW'(PAT_W)) ? fill : fill + 1'b1;
    hit  = (f_nx == FW'(PAT_W)) && (h_nx == pat);
    acc  = bus.w_vld && !bus.pat_ld;
  end
  // fill gates out bits that arrived before a reset or pattern load
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pat  <= PAT_RST;
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
    end else if (bus.pat_ld) begin
      pat  <= bus.pat_in;
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
    end else if (bus.w_vld) begin
      z    <= hit;
      hist <= (hit && !bus.overlap) ? '0 : h_nx;
      fill <= (hit && !bus.overlap) ? '0 : f_nx;
    end
  assign bus.z = z;
`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (acc && hit && !(&cnt)) cnt <= cnt + 1'b1;
  assign bus.match_cnt = cnt;
`else
  logic unused_acc;
  assign unused_acc    = acc;
  assign bus.match_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed and random stimulus against a bit-queue reference model, two configurations
module tb_seq_detect_param;
`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) b0 ();
  seq_detect_param_if #(.PAT_W(4), .CNT_W(2)) b1 ();
  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1101), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1111), .CNT_W(2)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  bit [3:0] pat_m [2];
  bit       q [2][$];
  bit       z_m [2];
  int       cnt_m [2];
  int       cmax [2] = '{255, 3};
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_all();
    chk("z0", {7'd0, b0.z}, {7'd0, z_m[0]});
    chk("cnt0", b0.match_cnt, CNT_ON ? 8'(cnt_m[0]) : 8'd0);
    chk("z1", {7'd0, b1.z}, {7'd0, z_m[1]});
    chk("cnt1", {6'd0, b1.match_cnt}, CNT_ON ? 8'(cnt_m[1]) : 8'd0);
  endtask
  task automatic model_reset();
    pat_m = '{4'b1101, 4'b1111};
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      z_m[i] = 1'b0;
      cnt_m[i] = 0;
    end
  endtask
  // a match is simply "the last four bits accepted since the last clear spell the pattern"
  task automatic model_edge(input bit wb, vb, ob, lb, input bit [3:0] pb);
    for (int i = 0; i < 2; i++) begin
      if (lb) begin
        pat_m[i] = pb;
        q[i].delete();
        z_m[i] = 1'b0;
      end else if (vb) begin
        bit m;
        q[i].push_back(wb);
        if (q[i].size() > 4) void'(q[i].pop_front());
        m = (q[i].size() == 4);
        for (int k = 0; k < q[i].size(); k++)
          if (q[i][k] != pat_m[i][3-k]) m = 1'b0;
        z_m[i] = m;
        if (m) begin
          if (cnt_m[i] < cmax[i]) cnt_m[i]++;
          if (!ob) q[i].delete();
        end
      end
    end
  endtask
  task automatic step(input bit wb, vb, ob, lb, input bit [3:0] pb);
    @(negedge clk);
    b0.w = wb; b0.w_vld = vb; b0.overlap = ob; b0.pat_ld = lb; b0.pat_in = pb;
    b1.w = wb; b1.w_vld = vb; b1.overlap = ob; b1.pat_ld = lb; b1.pat_in = pb;
    @(posedge clk);
    model_edge(wb, vb, ob, lb, pb);
    #1 chk_all();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 chk_all();
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic bits(input bit [6:0] s, input int n, input bit ob, input int gap);
    for (int k = n - 1; k >= 0; k--) begin
      step(s[k], 1'b1, ob, 1'b0, 4'd0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, ob, 1'b0, 4'd0);
    end
  endtask
  initial begin
    b0.w = 0; b0.w_vld = 0; b0.overlap = 1; b0.pat_ld = 0; b0.pat_in = 0;
    b1.w = 0; b1.w_vld = 0; b1.overlap = 1; b1.pat_ld = 0; b1.pat_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 chk_all();
    rst = 1'b1;
    bits(7'b1101, 4, 1'b1, 0);
    chk("basic_z", {7'd0, b0.z}, 8'd1);
    chk("basic_cnt", b0.match_cnt, CNT_ON ? 8'd1 : 8'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("basic_fall", {7'd0, b0.z}, 8'd0);
    do_reset();
    bits(7'b1101101, 7, 1'b1, 0);
    chk("ovl_cnt", b0.match_cnt, CNT_ON ? 8'd2 : 8'd0);
    do_reset();
    bits(7'b1101101, 7, 1'b0, 0);
    chk("novl_cnt", b0.match_cnt, CNT_ON ? 8'd1 : 8'd0);
    do_reset();
    bits(7'b1101, 4, 1'b1, 3);
    chk("gap_z", {7'd0, b0.z}, 8'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
    chk("ld_z", {7'd0, b0.z}, 8'd0);
    bits(7'b000, 3, 1'b1, 0);
    chk("ld_3rd", {7'd0, b0.z}, 8'd0);
    bits(7'b0, 1, 1'b1, 0);
    chk("ld_4th", {7'd0, b0.z}, 8'd1);
    do_reset();
    bits(7'b1111111, 7, 1'b1, 0);
    bits(7'b1, 1, 1'b1, 0);
    chk("sat_z", {7'd0, b1.z}, 8'd1);
    chk("sat_cnt", {6'd0, b1.match_cnt}, CNT_ON ? 8'd3 : 8'd0);
    do_reset();
    bits(7'b110, 3, 1'b1, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1 chk_all();
    #1 rst = 1'b1;
    bits(7'b1, 1, 1'b1, 0);
    chk("post_rst", {7'd0, b0.z}, 8'd0);
    bits(7'b101, 3, 1'b1, 0);
    chk("post_rst_match", {7'd0, b0.z}, 8'd1);
    for (int n = 0; n < 400; n++)
      step(1'($urandom), ($urandom_range(3) != 0), 1'($urandom),
           ($urandom_range(15) == 0), 4'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
